// File: rtl/pwm_seq_pkg.sv
// ---------------------------------------------------------------------------
// pwm_seq_pkg
//   Shared constants for the PWM breathe sequencer:
//     - DUTY_W_DEFAULT : default duty width
//     - ST_*           : 3-bit FSM state encodings (IDLE=0 .. HOLD_LO=5)
// ---------------------------------------------------------------------------
package pwm_seq_pkg;

  localparam int DUTY_W_DEFAULT = 6;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_STATIC  = 3'd1;
  localparam logic [2:0] ST_RAMP_UP = 3'd2;
  localparam logic [2:0] ST_HOLD_HI = 3'd3;
  localparam logic [2:0] ST_RAMP_DN = 3'd4;
  localparam logic [2:0] ST_HOLD_LO = 3'd5;

endpackage

// File: rtl/pwm_step_timer.sv
// ---------------------------------------------------------------------------
// pwm_step_timer
//   Counts PWM period_end ticks; a single instance serves both ramp-step and
//   hold timing, with the terminal value supplied by the owner.
// Ports:
//   clk     in  system clock
//   rst     in  synchronous active-high reset
//   clr_i   in  clear the count (wins over tick_i)
//   tick_i  in  period_end pulse
//   term_i  in  terminal count value (periods - 1)
//   tc_o    out high on a tick that lands on the terminal count
// ---------------------------------------------------------------------------
module pwm_step_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             tick_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear, wrap at terminal, or advance on a tick.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == term_i) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Combinational so the owner can act on the same period_end.
  assign tc_o = tick_i && (cnt_q == term_i);

endmodule

// File: rtl/pwm_breathe_sequencer.sv
// ---------------------------------------------------------------------------
// pwm_breathe_sequencer
//   Feeds the PWM comparator its duty value. Static mode passes ref_duty
//   through; breathe mode ramps a level 0 -> ref -> 0 with holds at the
//   peak and trough. Every duty update is committed on a period boundary.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   enable      0 forces IDLE immediately (duty 0, gate off)
//   breathe_en  1 = breathe mode, 0 = static mode
//   ref_duty    static duty / breathe ceiling
//   period_end  one-cycle pulse on the last count of each PWM period
//   duty        registered duty for the comparator
//   duty_load   one-cycle pulse, one clk after the period_end it follows
//   pwm_gate    pin output enable
//   state       current FSM state (debug)
// Build option:
//   PWM_SEQ_GAMMA_EN - breathe duty = (level*(level+1)) >> DUTY_W;
//                      otherwise duty = level and no multiplier exists.
// ---------------------------------------------------------------------------
module pwm_breathe_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int DUTY_W       = DUTY_W_DEFAULT,
  parameter int STEP_PERIODS = 4,
  parameter int HOLD_PERIODS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              breathe_en,
  input  logic [DUTY_W-1:0] ref_duty,
  input  logic              period_end,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_load,
  output logic              pwm_gate,
  output logic [2:0]        state
);

  localparam int MAX_P  = (STEP_PERIODS > HOLD_PERIODS) ? STEP_PERIODS : HOLD_PERIODS;
  localparam int CNT_W  = ($clog2(MAX_P) < 1) ? 1 : $clog2(MAX_P);

  logic [2:0]        state_q, state_d;
  logic [DUTY_W-1:0] level_q, level_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              load_q, load_d;
  logic              gate_q, gate_d;

  logic              tc_s;
  logic              clr_s;
  logic [CNT_W-1:0]  term_s;
  logic [DUTY_W:0]   up_ext_s;
  logic [DUTY_W:0]   ref_ext_s;
  logic [DUTY_W:0]   stepped_s;

  // Breathe-mode level to duty mapping.
  function automatic logic [DUTY_W-1:0] shape_f(input logic [DUTY_W-1:0] lvl);
`ifdef PWM_SEQ_GAMMA_EN
    logic [2*DUTY_W:0] prod;
    prod    = (2*DUTY_W+1)'(lvl) * (2*DUTY_W+1)'({1'b0, lvl} + {{DUTY_W{1'b0}}, 1'b1});
    shape_f = DUTY_W'(prod >> DUTY_W);
`else
    shape_f = lvl;
`endif
  endfunction

  // One extra bit keeps level+1 from wrapping before the ceiling compare;
  // taking min() also clamps the level when ref_duty has dropped below it.
  assign up_ext_s  = {1'b0, level_q} + {{DUTY_W{1'b0}}, 1'b1};
  assign ref_ext_s = {1'b0, ref_duty};
  assign stepped_s = (up_ext_s < ref_ext_s) ? up_ext_s : ref_ext_s;

  assign term_s = ((state_q == ST_HOLD_HI) || (state_q == ST_HOLD_LO))
                ? CNT_W'(HOLD_PERIODS - 1) : CNT_W'(STEP_PERIODS - 1);

  // Every state change restarts step/hold timing from zero.
  assign clr_s = (!enable) || (state_q == ST_IDLE) || (state_d != state_q);

  pwm_step_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clr_s),
    .tick_i (period_end),
    .term_i (term_s),
    .tc_o   (tc_s)
  );

  // FSM, level and duty next-state logic.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    duty_d  = duty_q;
    gate_d  = gate_q;
    load_d  = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      level_d = '0;
      duty_d  = '0;
      gate_d  = 1'b0;
    end else if (state_q == ST_IDLE) begin
      state_d = breathe_en ? ST_RAMP_UP : ST_STATIC;
      level_d = '0;
      gate_d  = 1'b1;
    end else if (state_q > ST_HOLD_LO) begin
      state_d = ST_IDLE;
      level_d = '0;
      duty_d  = '0;
      gate_d  = 1'b0;
    end else if (period_end) begin
      gate_d = 1'b1;
      load_d = 1'b1;
      if (!breathe_en) begin
        state_d = ST_STATIC;
        level_d = '0;
      end else begin
        case (state_q)
          ST_STATIC: begin
            state_d = ST_RAMP_UP;
            level_d = '0;
          end
          ST_RAMP_UP: begin
            if (tc_s) begin
              level_d = stepped_s[DUTY_W-1:0];
              if (stepped_s >= ref_ext_s) begin
                state_d = ST_HOLD_HI;
              end else begin
                state_d = ST_RAMP_UP;
              end
            end else begin
              level_d = level_q;
            end
          end
          ST_HOLD_HI: begin
            state_d = tc_s ? ST_RAMP_DN : ST_HOLD_HI;
          end
          ST_RAMP_DN: begin
            if (tc_s) begin
              level_d = (level_q == '0) ? '0 : level_q - {{(DUTY_W-1){1'b0}}, 1'b1};
              if (level_q <= {{(DUTY_W-1){1'b0}}, 1'b1}) begin
                state_d = ST_HOLD_LO;
              end else begin
                state_d = ST_RAMP_DN;
              end
            end else begin
              level_d = level_q;
            end
          end
          ST_HOLD_LO: begin
            state_d = tc_s ? ST_RAMP_UP : ST_HOLD_LO;
          end
          default: begin
            state_d = ST_IDLE;
            level_d = '0;
          end
        endcase
      end
      duty_d = (state_d == ST_STATIC) ? ref_duty : shape_f(level_d);
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      level_q <= '0;
      duty_q  <= '0;
      load_q  <= 1'b0;
      gate_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      duty_q  <= duty_d;
      load_q  <= load_d;
      gate_q  <= gate_d;
    end
  end

  assign duty      = duty_q;
  assign duty_load = load_q;
  assign pwm_gate  = gate_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pwm_breathe_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pwm_breathe_sequencer
//   Directed bench for pwm_breathe_sequencer with default parameters
//   (DUTY_W=6, STEP_PERIODS=4, HOLD_PERIODS=16).
// ---------------------------------------------------------------------------
module tb_pwm_breathe_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       breathe_en;
  logic [5:0] ref_duty;
  logic       period_end;
  logic [5:0] duty;
  logic       duty_load;
  logic       pwm_gate;
  logic [2:0] state;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pwm_breathe_sequencer #(
    .DUTY_W       (6),
    .STEP_PERIODS (4),
    .HOLD_PERIODS (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .breathe_en (breathe_en),
    .ref_duty   (ref_duty),
    .period_end (period_end),
    .duty       (duty),
    .duty_load  (duty_load),
    .pwm_gate   (pwm_gate),
    .state      (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; pe is presented for exactly that edge. Returns #1 after it.
  task automatic tick(input logic pe);
    @(negedge clk);
    period_end = pe;
    @(posedge clk);
    #1;
    period_end = 1'b0;
  endtask

  // Breathe profile for ref=6: 24 up, 16 hold, 24 down, 16 hold.
  function automatic int exp_duty(input int n);
    int m;
    m = (n - 1) % 80 + 1;
    if (m <= 24) return m / 4;
    else if (m <= 40) return 6;
    else if (m <= 64) return 6 - (m - 40) / 4;
    else return 0;
  endfunction

  function automatic int exp_state(input int n);
    int m;
    m = (n - 1) % 80 + 1;
    if (m < 24) return 2;
    else if (m < 40) return 3;
    else if (m < 64) return 4;
    else if (m < 80) return 5;
    else return 2;
  endfunction

  initial begin
    int loads;
    rst = 1'b1; enable = 1'b0; breathe_en = 1'b0; ref_duty = 6'd0; period_end = 1'b0;
    tick(1'b0);
    tick(1'b0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_duty",  32'(duty),  32'd0);
    chk("rst_gate",  32'(pwm_gate), 32'd0);
    chk("rst_load",  32'(duty_load), 32'd0);
    rst = 1'b0;

    // Disabled: period_end every 64 clk, nothing may happen.
    loads = 0;
    for (int i = 0; i < 1000; i++) begin
      tick((i % 64) == 63);
      loads += int'(duty_load);
    end
    chk("off_duty",  32'(duty), 32'd0);
    chk("off_gate",  32'(pwm_gate), 32'd0);
    chk("off_loads", 32'(loads), 32'd0);
    chk("off_state", 32'(state), 32'd0);

    // Static mode.
    enable = 1'b1; breathe_en = 1'b0; ref_duty = 6'd6;
    tick(1'b0);
    chk("st_state", 32'(state), 32'd1);
    chk("st_gate",  32'(pwm_gate), 32'd1);
    chk("st_duty0", 32'(duty), 32'd0);
    chk("st_load0", 32'(duty_load), 32'd0);
    tick(1'b0);
    tick(1'b1);
    chk("st_duty6", 32'(duty), 32'd6);
    chk("st_load",  32'(duty_load), 32'd1);
    tick(1'b0);
    chk("st_load_pulse", 32'(duty_load), 32'd0);
    ref_duty = 6'd16;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0);
      chk("st_hold6", 32'(duty), 32'd6);
    end
    tick(1'b1);
    chk("st_duty16", 32'(duty), 32'd16);
    chk("st_load16", 32'(duty_load), 32'd1);

    // Breathe with ref=6, one full 80-period cycle plus one step.
    enable = 1'b0;
    tick(1'b0);
    chk("dis_idle", 32'(state), 32'd0);
    enable = 1'b1; breathe_en = 1'b1; ref_duty = 6'd6;
    tick(1'b0);
    chk("br_entry_state", 32'(state), 32'd2);
    chk("br_entry_duty",  32'(duty), 32'd0);
    for (int n = 1; n <= 84; n++) begin
      tick(1'b1);
      chk($sformatf("br_duty_%0d", n),  32'(duty), 32'(exp_duty(n)));
      chk($sformatf("br_state_%0d", n), 32'(state), 32'(exp_state(n)));
      chk($sformatf("br_load_%0d", n),  32'(duty_load), 32'd1);
      tick(1'b0);
      chk($sformatf("br_unload_%0d", n), 32'(duty_load), 32'd0);
      tick(1'b0);
      tick(1'b0);
    end

    // Ceiling drops below the level mid-ramp.
    enable = 1'b0;
    tick(1'b0);
    enable = 1'b1; ref_duty = 6'd32;
    tick(1'b0);
    for (int n = 0; n < 40; n++) begin
      tick(1'b1);
      tick(1'b0);
    end
    chk("drop_lvl10",  32'(duty), 32'd10);
    chk("drop_ramp",   32'(state), 32'd2);
    ref_duty = 6'd2;
    for (int n = 0; n < 3; n++) begin
      tick(1'b1);
      tick(1'b0);
    end
    chk("drop_wait_duty",  32'(duty), 32'd10);
    chk("drop_wait_state", 32'(state), 32'd2);
    tick(1'b1);
    chk("drop_duty2",  32'(duty), 32'd2);
    chk("drop_holdhi", 32'(state), 32'd3);

    // Reach RAMP_DN, then disable on a period_end.
    for (int n = 0; n < 16; n++) begin
      tick(1'b1);
      tick(1'b0);
    end
    chk("dn_state", 32'(state), 32'd4);
    chk("dn_duty",  32'(duty), 32'd2);
    enable = 1'b0;
    tick(1'b1);
    chk("kill_state", 32'(state), 32'd0);
    chk("kill_duty",  32'(duty), 32'd0);
    chk("kill_gate",  32'(pwm_gate), 32'd0);
    chk("kill_load",  32'(duty_load), 32'd0);

`ifdef PWM_SEQ_GAMMA_EN
    enable = 1'b1; breathe_en = 1'b1; ref_duty = 6'd63;
    tick(1'b0);
    for (int n = 1; n <= 252; n++) begin
      tick(1'b1);
      if (n == 4)   chk("gam_l1",  32'(duty), 32'd0);
      if (n == 128) chk("gam_l32", 32'(duty), 32'd16);
      if (n == 252) begin
        chk("gam_l63",   32'(duty), 32'd63);
        chk("gam_state", 32'(state), 32'd3);
      end
      tick(1'b0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
